// File: rtl/dds_clk_pkg.sv
// rtl/dds_clk_pkg.sv - shared constants, state encoding and divisor step helpers
package dds_clk_pkg;

    localparam int CNT_W       = 20;
    localparam int DIV_DEFAULT = 5000;
    localparam int DIV_MIN     = 2;
    localparam int DIV_MAX     = 1000000;
    localparam int STEP        = 500;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    // Faster output: shrink the divisor, saturating at DIV_MIN (one extra bit so it cannot wrap)
    function automatic logic [CNT_W-1:0] div_step_down(input logic [CNT_W-1:0] d);
        logic [CNT_W:0] wide;
        logic [CNT_W-1:0] res;
        wide = {1'b0, d};
        if (wide < (CNT_W+1)'(DIV_MIN + STEP)) begin
            res = CNT_W'(DIV_MIN);
        end else begin
            wide = wide - (CNT_W+1)'(STEP);
            res  = wide[CNT_W-1:0];
        end
        return res;
    endfunction

    // Slower output: grow the divisor, saturating at DIV_MAX (one extra bit so it cannot wrap)
    function automatic logic [CNT_W-1:0] div_step_up(input logic [CNT_W-1:0] d);
        logic [CNT_W:0] wide;
        logic [CNT_W-1:0] res;
        wide = {1'b0, d} + (CNT_W+1)'(STEP);
        if (wide > (CNT_W+1)'(DIV_MAX)) begin
            res = CNT_W'(DIV_MAX);
        end else begin
            res = wide[CNT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// rtl/clk_div_ctrl_if.sv - divisor config request port (valid/ready plus reject pulse)
interface clk_div_ctrl_if;
    import dds_clk_pkg::*;

    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );

endinterface

// File: rtl/div_core.sv
// rtl/div_core.sv - half-period counter producing tick and the square wave
module div_core
    import dds_clk_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div_cur,
    output logic             at_end,
    output logic             tick,
    output logic             signal
);

    logic [CNT_W-1:0] cnt;

    // Last count of the current half-period; div_cur >= DIV_MIN so the subtract never wraps
    assign at_end = (cnt == div_cur - CNT_W'(1));

    // Count 0..div_cur-1, toggle and tick on the last count; disabled output idles low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            tick   <= 1'b0;
            signal <= 1'b0;
        end else if (!en) begin
            cnt    <= '0;
            tick   <= 1'b0;
            signal <= 1'b0;
        end else if (at_end) begin
            cnt    <= '0;
            tick   <= 1'b1;
            signal <= ~signal;
        end else begin
            cnt    <= load ? '0 : cnt + CNT_W'(1);
            tick   <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - configurable sample-clock generator with glitch-free divisor reload
module clk_div_ctrl
    import dds_clk_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    clk_div_ctrl_if.slave        cfg,
    input  logic                 step_up,
    input  logic                 step_dn,
    output logic                 tick,
    output logic                 signal,
    output logic [CNT_W-1:0]     div_cur,
    output logic                 pending
);

    state_t           state;
    logic [CNT_W-1:0] pend_div;
    logic             up_q;
    logic             dn_q;
    logic             at_end;
    logic             up_edge;
    logic             dn_edge;
    logic             in_range;
    logic             apply;

    assign up_edge  = step_up & ~up_q;
    assign dn_edge  = step_dn & ~dn_q;
    assign in_range = (cfg.cfg_div >= CNT_W'(DIV_MIN)) && (cfg.cfg_div <= CNT_W'(DIV_MAX));
    // Swap only where the waveform is already changing, or immediately when stopped
    assign apply    = (state == S_PEND) && (!en || at_end);

    div_core u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .load    (apply),
        .div_cur (div_cur),
        .at_end  (at_end),
        .tick    (tick),
        .signal  (signal)
    );

    // Request FSM: accept a config or a single button step, hold it until a boundary, then apply
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            pend_div      <= CNT_W'(DIV_DEFAULT);
            div_cur       <= CNT_W'(DIV_DEFAULT);
            pending       <= 1'b0;
            cfg.cfg_ready <= 1'b1;
            cfg.cfg_err   <= 1'b0;
            up_q          <= 1'b0;
            dn_q          <= 1'b0;
        end else begin
            up_q        <= step_up;
            dn_q        <= step_dn;
            cfg.cfg_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg.cfg_valid) begin
                        if (in_range) begin
                            pend_div      <= cfg.cfg_div;
                            state         <= S_PEND;
                            pending       <= 1'b1;
                            cfg.cfg_ready <= 1'b0;
                        end else begin
                            cfg.cfg_err   <= 1'b1;
                        end
                    end else if (up_edge != dn_edge) begin
                        pend_div      <= up_edge ? div_step_down(div_cur) : div_step_up(div_cur);
                        state         <= S_PEND;
                        pending       <= 1'b1;
                        cfg.cfg_ready <= 1'b0;
                    end
                end
                S_PEND: begin
                    if (apply) begin
                        div_cur       <= pend_div;
                        state         <= S_IDLE;
                        pending       <= 1'b0;
                        cfg.cfg_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
